amm_burst_slave_mem: RTL and testbench

//  Parametrised Avalon-MM burst slave backed by on-chip RAM: the memory-under-test model for the checker.

---
 rtl/amm_burst_slave_mem_if.sv | 29 ++
 rtl/amm_burst_slave_mem.sv | 126 ++++++++++++
 tb/tb_amm_burst_slave_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/amm_burst_slave_mem_if.sv
// rtl/amm_burst_slave_mem_if.sv - Avalon-MM burst bus between checker master and memory slave
interface amm_burst_slave_mem_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic               read_i;
  logic               write_i;
  logic [ADDR_W-1:0]  address_i;
  logic [BURST_W-1:0] burstcount_i;
  logic [BE_W-1:0]    byteenable_i;
  logic [DATA_W-1:0]  writedata_i;
  logic               waitrequest_o;
  logic [DATA_W-1:0]  readdata_o;
  logic               readdatavalid_o;
  logic               protocol_err_o;

  modport master (
    output read_i, write_i, address_i, burstcount_i, byteenable_i, writedata_i,
    input  waitrequest_o, readdata_o, readdatavalid_o, protocol_err_o
  );

  modport slave (
    input  read_i, write_i, address_i, burstcount_i, byteenable_i, writedata_i,
    output waitrequest_o, readdata_o, readdatavalid_o, protocol_err_o
  );
endinterface

// File: rtl/amm_burst_slave_mem.sv
// rtl/amm_burst_slave_mem.sv - Avalon-MM burst slave on on-chip RAM with fixed-latency pipelined reads
module amm_burst_slave_mem #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BURST_W      = 8,
  parameter int READ_LATENCY = 2
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  amm_burst_slave_mem_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int LAT  = READ_LATENCY;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t             state_q, state_d;
  logic               init_q;
  logic               err_q;
  logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
  logic [BURST_W-1:0] wr_left_q, rd_left_q, out_left_q;
  logic [LAT-1:0]     vpipe_q;
  logic [DATA_W-1:0]  dpipe_q [LAT];
  logic [DATA_W-1:0]  mem [2**ADDR_W];

  logic               wait_s, idle_wr, idle_rd, wr_beat, mem_we, issue, last_out, err_set;
  logic [BURST_W-1:0] bc_eff;
  logic [ADDR_W-1:0]  mem_waddr;

  // init_q keeps waitrequest high until the first edge after reset release
  assign wait_s    = init_q | (state_q == RD_BURST);
  assign bc_eff    = (bus.burstcount_i == '0) ? BURST_W'(1) : bus.burstcount_i;
  assign idle_wr   = (state_q == IDLE) && bus.write_i && !wait_s;
  assign idle_rd   = (state_q == IDLE) && bus.read_i && !bus.write_i && !wait_s;
  assign wr_beat   = (state_q == WR_BURST) && bus.write_i;
  assign mem_we    = idle_wr | wr_beat;
  assign mem_waddr = (state_q == IDLE) ? bus.address_i : wr_addr_q;
  assign issue     = (state_q == RD_BURST) && (rd_left_q != '0);
  assign last_out  = (state_q == RD_BURST) && vpipe_q[LAT-1] && (out_left_q == BURST_W'(1));
  assign err_set   = ((state_q == IDLE) && !wait_s && bus.write_i && bus.read_i)
                   | ((state_q == WR_BURST) && bus.read_i)
                   | ((idle_wr | idle_rd) && (bus.burstcount_i == '0));

  assign bus.waitrequest_o   = wait_s;
  assign bus.readdatavalid_o = vpipe_q[LAT-1];
  assign bus.readdata_o      = dpipe_q[LAT-1];
  assign bus.protocol_err_o  = err_q;

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: single-beat writes stay in IDLE, reads leave once the last beat is on the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (idle_wr && (bc_eff != BURST_W'(1))) state_d = WR_BURST;
        else if (idle_rd)                         state_d = RD_BURST;
      end
      WR_BURST: if (bus.write_i && (wr_left_q == BURST_W'(1))) state_d = IDLE;
      RD_BURST: if (last_out) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // burst bookkeeping: write address/remaining beats, read issue and delivery counters, sticky error
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      init_q     <= 1'b1;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_left_q  <= '0;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
    end else begin
      init_q <= 1'b0;
      if (err_set) err_q <= 1'b1;
      if (idle_wr) begin
        wr_addr_q <= bus.address_i + ADDR_W'(1);
        wr_left_q <= bc_eff - BURST_W'(1);
      end else if (wr_beat) begin
        wr_addr_q <= wr_addr_q + ADDR_W'(1);
        wr_left_q <= wr_left_q - BURST_W'(1);
      end
      if (idle_rd) begin
        rd_addr_q  <= bus.address_i;
        rd_left_q  <= bc_eff;
        out_left_q <= bc_eff;
      end else begin
        if (issue) begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
          rd_left_q <= rd_left_q - BURST_W'(1);
        end
        if ((state_q == RD_BURST) && vpipe_q[LAT-1]) out_left_q <= out_left_q - BURST_W'(1);
      end
    end
  end

  // RAM write port with per-byte enables; contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byteenable_i[i]) mem[mem_waddr][i*8 +: 8] <= bus.writedata_i[i*8 +: 8];
      end
    end
  end

  // read pipeline: data stages only move with valid so the output holds the last beat
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vpipe_q <= '0;
      for (int i = 0; i < LAT; i++) dpipe_q[i] <= '0;
    end else begin
      vpipe_q[0] <= issue;
      if (issue) dpipe_q[0] <= mem[rd_addr_q];
      for (int i = 1; i < LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        if (vpipe_q[i-1]) dpipe_q[i] <= dpipe_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_amm_burst_slave_mem.sv
// tb/tb_amm_burst_slave_mem.sv - randomized self-checking bench for amm_burst_slave_mem
module tb_amm_burst_slave_mem;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem_m [1024];

  always #5 clk = ~clk;

  amm_burst_slave_mem_if #(.ADDR_W(10), .DATA_W(32), .BURST_W(8)) bus ();

  amm_burst_slave_mem #(.ADDR_W(10), .DATA_W(32), .BURST_W(8), .READ_LATENCY(LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.waitrequest_o && n < 20) begin
      tick();
      n++;
    end
    chk("ready", 32'(bus.waitrequest_o), 32'd0);
  endtask

  task automatic do_write(input logic [9:0] addr, input int bc_field, input logic [31:0] d0,
                          input logic [3:0] be, input bit rand_be, input bit with_read,
                          input int stall_at, input int stall_n);
    int n;
    logic [31:0] d;
    logic [3:0] e;
    logic [9:0] a;
    n = (bc_field == 0) ? 1 : bc_field;
    wait_ready();
    for (int b = 0; b < n; b++) begin
      if (b == stall_at && b > 0) begin
        for (int s = 0; s < stall_n; s++) begin
          bus.write_i = 1'b0;
          tick();
        end
      end
      d = (b == 0) ? d0 : $urandom;
      e = rand_be ? 4'($urandom) : be;
      bus.write_i      = 1'b1;
      bus.read_i       = with_read && (b == 0);
      bus.address_i    = (b == 0) ? addr : 10'($urandom);
      bus.burstcount_i = (b == 0) ? 8'(bc_field) : 8'($urandom);
      bus.byteenable_i = e;
      bus.writedata_i  = d;
      if (b > 0) chk("wr_wait", 32'(bus.waitrequest_o), 32'd0);
      tick();
      a = addr + 10'(b);
      for (int i = 0; i < 4; i++) if (e[i]) mem_m[a][i*8 +: 8] = d[i*8 +: 8];
    end
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] addr, input int bc, input int abort_beat);
    int n;
    bit exp_v;
    logic [31:0] last;
    logic [9:0] a;
    n = (bc == 0) ? 1 : bc;
    last = 32'd0;
    wait_ready();
    bus.read_i       = 1'b1;
    bus.address_i    = addr;
    bus.burstcount_i = 8'(bc);
    tick();
    for (int c = 0; c <= LAT + n + 1; c++) begin
      if (c > 0) tick();
      if (c < LAT + n) begin
        bus.read_i       = 1'($urandom);
        bus.write_i      = 1'($urandom);
        bus.address_i    = 10'($urandom);
        bus.burstcount_i = 8'($urandom_range(0, 3));
        bus.writedata_i  = $urandom;
        bus.byteenable_i = 4'hF;
      end else begin
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
      end
      exp_v = (c >= LAT) && (c < LAT + n);
      chk("rd_valid", 32'(bus.readdatavalid_o), 32'(exp_v));
      chk("rd_wait", 32'(bus.waitrequest_o), 32'(c < LAT + n));
      if (exp_v) begin
        a = addr + 10'(c - LAT);
        last = mem_m[a];
        chk("rd_data", bus.readdata_o, last);
      end else if (c >= LAT + n) begin
        chk("rd_hold", bus.readdata_o, last);
      end
      if (abort_beat >= 0 && c == LAT + abort_beat) begin
        #2 rst_n = 1'b0;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.readdatavalid_o), 32'd0);
        chk("rst_wait", 32'(bus.waitrequest_o), 32'd1);
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = '0; bus.burstcount_i = '0;
    bus.byteenable_i = '0; bus.writedata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", 32'(bus.waitrequest_o), 32'd1);
    chk("rst_valid", 32'(bus.readdatavalid_o), 32'd0);
    chk("rst_rdata", bus.readdata_o, 32'd0);
    chk("rst_err", 32'(bus.protocol_err_o), 32'd0);
    rst_n = 1'b1;
    #1 chk("wait_before_edge", 32'(bus.waitrequest_o), 32'd1);
    tick();
    chk("wait_after_edge", 32'(bus.waitrequest_o), 32'd0);

    for (int k = 0; k < 5; k++) do_write(10'(k * 205), 205, $urandom, 4'hF, 1'b0, 1'b0, -1, 0);

    do_write(10'd5, 1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, -1, 0);
    do_read(10'd5, 1, -1);
    do_write(10'd5, 1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, -1, 0);
    do_write(10'd5, 1, 32'h11223344, 4'b0101, 1'b0, 1'b0, -1, 0);
    do_read(10'd5, 1, -1);
    chk("be_merge_value", bus.readdata_o, 32'hAA22CC44);
    do_write(10'd1022, 4, $urandom, 4'hF, 1'b0, 1'b0, 2, 2);
    do_read(10'd1022, 4, -1);
    chk("err_clean", 32'(bus.protocol_err_o), 32'd0);

    do_write(10'd100, 0, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, -1, 0);
    chk("err_bc0", 32'(bus.protocol_err_o), 32'd1);
    do_read(10'd100, 2, -1);

    rst_n = 1'b0;
    #1;
    chk("rst2_err", 32'(bus.protocol_err_o), 32'd0);
    chk("rst2_wait", 32'(bus.waitrequest_o), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    do_write(10'd200, 1, 32'h12345678, 4'hF, 1'b0, 1'b1, -1, 0);
    for (int c = 0; c < LAT + 2; c++) begin
      chk("rw_no_rdata", 32'(bus.readdatavalid_o), 32'd0);
      tick();
    end
    chk("err_rw", 32'(bus.protocol_err_o), 32'd1);
    do_read(10'd200, 1, -1);

    do_write(10'd300, 4, $urandom, 4'hF, 1'b1, 1'b0, -1, 0);
    do_read(10'd300, 4, 1);
    tick();
    chk("rst3_valid", 32'(bus.readdatavalid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    do_read(10'd300, 4, -1);
    do_write(10'd500, 1, 32'h0BADF00D, 4'hF, 1'b0, 1'b1, -1, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(10'($urandom), $urandom_range(1, 6), $urandom, 4'hF, 1'b1, 1'b0,
                 $urandom_range(1, 5), $urandom_range(0, 2));
      else
        do_read(10'($urandom), $urandom_range(1, 6), -1);
    end
    chk("err_sticky", 32'(bus.protocol_err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
